multi_cycle_ctrl: RTL

Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Drives the 3-bit AluOp into Alu_Control and supplies all register-file, PC and memory strobes.
- Handles memory ready handshakes, a bus watchdog, and sticky traps on illegal opcodes and bus timeouts.

---
 rtl/rv_ctrl_pkg.sv | 55 +++++
 rtl/multi_cycle_ctrl_if.sv | 34 +++
 rtl/opcode_class_dec.sv | 30 +++
 rtl/multi_cycle_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// ALU operation classes, FSM states and the strobe encodings.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_STORE  = 3'b001;
    localparam logic [2:0] ALUOP_BRANCH = 3'b010;
    localparam logic [2:0] ALUOP_JAL    = 3'b011;
    localparam logic [2:0] ALUOP_LUI    = 3'b100;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_JAL,
        CLS_JALR
    } op_class_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle of instruction/handshake inputs and control strobes between the
// control FSM (master) and the datapath/memory side (slave).
interface multi_cycle_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] inst;
    logic             imem_ready;
    logic             dmem_ready;
    logic             branch_taken;
    logic             imem_req;
    logic             ir_we;
    logic [2:0]       AluOp;
    logic             alu_src_b;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             retire;
    logic [1:0]       trap;

    modport master (
        input  inst, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_we, AluOp, alu_src_b, dmem_req, dmem_we,
               reg_we, wb_sel, pc_we, pc_sel, retire, trap
    );

    modport slave (
        output inst, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_we, AluOp, alu_src_b, dmem_req, dmem_we,
               reg_we, wb_sel, pc_we, pc_sel, retire, trap
    );
endinterface

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: maps inst[6:0] to an instruction class,
// its ALU operation class and an illegal-opcode flag.
module opcode_class_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // Unknown opcodes fall through to the illegal defaults.
    always_comb begin
        op_class = CLS_NONE;
        alu_op   = ALUOP_ADD;
        illegal  = 1'b1;
        case (opcode)
            OPC_R:      begin op_class = CLS_R;      alu_op = ALUOP_RTYPE;  illegal = 1'b0; end
            OPC_I_ALU:  begin op_class = CLS_I_ALU;  alu_op = ALUOP_ADD;    illegal = 1'b0; end
            OPC_LOAD:   begin op_class = CLS_LOAD;   alu_op = ALUOP_ADD;    illegal = 1'b0; end
            OPC_JALR:   begin op_class = CLS_JALR;   alu_op = ALUOP_ADD;    illegal = 1'b0; end
            OPC_STORE:  begin op_class = CLS_STORE;  alu_op = ALUOP_STORE;  illegal = 1'b0; end
            OPC_BRANCH: begin op_class = CLS_BRANCH; alu_op = ALUOP_BRANCH; illegal = 1'b0; end
            OPC_LUI:    begin op_class = CLS_LUI;    alu_op = ALUOP_LUI;    illegal = 1'b0; end
            OPC_JAL:    begin op_class = CLS_JAL;    alu_op = ALUOP_JAL;    illegal = 1'b0; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB, guards both memory waits
// with a watchdog and parks in a sticky TRAP state on faults.
module multi_cycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    multi_cycle_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The count reaches TIMEOUT on the cycle it sits at TIMEOUT-1 with ready low.
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    op_class_t        cls_q;
    op_class_t        dec_class;
    logic [2:0]       alu_op_q;
    logic [2:0]       dec_alu_op;
    logic             dec_illegal;
    logic [CW-1:0]    wait_cnt;
    logic [1:0]       trap_q;
    logic [WIDTH-1:0] inst_word;
    logic             unused_inst_bits;
    logic             in_wait;
    logic             wait_ready;
    logic             wdog_trip;
    logic             src_imm;

    assign inst_word        = bus.inst;
    // Operand fields above the opcode are consumed by the datapath, not here.
    assign unused_inst_bits = ^inst_word[WIDTH-1:7];

    opcode_class_dec u_dec (
        .opcode   (inst_word[6:0]),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal)
    );

    assign in_wait    = (state == ST_FETCH) || (state == ST_MEM);
    assign wait_ready = (state == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign wdog_trip  = in_wait && !wait_ready && (wait_cnt == WAIT_LIMIT);
    assign src_imm    = (cls_q != CLS_R) && (cls_q != CLS_BRANCH);
    assign bus.trap   = trap_q;

    // State register; reset parks the FSM in START so every strobe drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_START;
        else     state <= state_next;
    end

    // Capture the instruction class and ALU class while decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q    <= CLS_NONE;
            alu_op_q <= ALUOP_ADD;
        end else if (state == ST_DECODE) begin
            cls_q    <= dec_class;
            alu_op_q <= dec_alu_op;
        end
    end

    // Watchdog: restarts on every state change, counts low-ready wait cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= '0;
        else if (state_next != state)   wait_cnt <= '0;
        else if (in_wait && !wait_ready) wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky trap cause; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  trap_q <= TRAP_NONE;
        else if (state == ST_DECODE && dec_illegal) trap_q <= TRAP_ILLEGAL;
        else if (wdog_trip)                        trap_q <= TRAP_BUS;
    end

    // Next-state selection and strobe decode from state plus latched class.
    always_comb begin
        state_next    = state;
        bus.imem_req  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.AluOp     = ALUOP_ADD;
        bus.alu_src_b = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = WB_ALU;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = PC_PLUS4;
        bus.retire    = 1'b0;
        case (state)
            ST_START: state_next = ST_FETCH;
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_we  = 1'b1;
                    state_next = ST_DECODE;
                end else if (wdog_trip) begin
                    state_next = ST_TRAP;
                end
            end
            ST_DECODE: state_next = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                bus.AluOp     = alu_op_q;
                bus.alu_src_b = src_imm;
                case (cls_q)
                    CLS_BRANCH: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = bus.branch_taken ? PC_IMM : PC_PLUS4;
                        bus.retire = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        bus.reg_we = 1'b1;
                        bus.wb_sel = WB_PC4;
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = (cls_q == CLS_JAL) ? PC_IMM : PC_ALU;
                        bus.retire = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    default:             state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                bus.AluOp     = alu_op_q;
                bus.alu_src_b = src_imm;
                bus.dmem_req  = 1'b1;
                bus.dmem_we   = (cls_q == CLS_STORE);
                if (bus.dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = PC_PLUS4;
                        bus.retire = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wdog_trip) begin
                    state_next = ST_TRAP;
                end
            end
            ST_WB: begin
                bus.AluOp     = alu_op_q;
                bus.alu_src_b = src_imm;
                bus.reg_we    = 1'b1;
                bus.wb_sel    = (cls_q == CLS_LOAD) ? WB_MEM : WB_ALU;
                bus.pc_we     = 1'b1;
                bus.pc_sel    = PC_PLUS4;
                bus.retire    = 1'b1;
                state_next    = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_START;
        endcase
    end

endmodule
